// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and helpers for the asyncfifo read-side packer.
// The state enum, byte width and output-count width function live here.
package fifo_rd_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    EMIT  = 2'd2
  } state_t;

  // Bits needed to hold a byte count of 0..bytes inclusive.
  function automatic int out_bytes_w(input int bytes);
    return $clog2(bytes + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed-word valid/ready stream for fifo_rd_packer.
// master is the packer side; slave is the FIFO/downstream environment.
interface fifo_rd_packer_if #(parameter int BYTES = 4);
  import fifo_rd_pkg::*;

  localparam int OBW = out_bytes_w(BYTES);

  logic                      empty;
  logic [BYTE_W-1:0]         dout;
  logic                      rd_en;
  logic [BYTE_W*BYTES-1:0]   out_data;
  logic [OBW-1:0]            out_bytes;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    input  empty, dout, out_ready,
    output rd_en, out_data, out_bytes, out_valid
  );

  modport slave (
    output empty, dout, out_ready,
    input  rd_en, out_data, out_bytes, out_valid
  );

endinterface

// File: rtl/fifo_rd_packer_lane_packer.sv
// Byte-lane register array for one output word.
// Writes one lane per cycle; clear wipes every lane so unused lanes read as zero.
module lane_packer
  import fifo_rd_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int IW    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    we,
  input  logic [IW-1:0]           idx,
  input  logic [BYTE_W-1:0]       din,
  output logic [BYTE_W*BYTES-1:0] data
);

  logic [BYTES-1:0][BYTE_W-1:0] lanes;

  // NOTE: this small array is reset like ordinary state because a partial word
  // must show zeros in lanes it never wrote; a large RAM would not be reset.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lanes <= '0;
    end else if (we) begin
      lanes[idx] <= din;
    end
  end

  assign data = lanes;

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-domain drain engine: pops FIFO bytes, packs them little-endian into
// BYTES-wide words and hands them downstream on valid/ready; flush emits a partial word.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 rd_clk,
  input  logic                 rst,
  input  logic                 flush,
  fifo_rd_packer_if.master     bus,
  output logic [CNT_W-1:0]     words_out,
  output logic                 busy
);

  localparam int CW = out_bytes_w(BYTES);
  localparam int IW = $clog2(BYTES);
  localparam logic [CW-1:0] FULL = CW'(BYTES);

  state_t                  state, state_nxt;
  logic [CW-1:0]           issued, issued_nxt;
  logic [CW-1:0]           captured, captured_nxt;
  logic                    pend;        // a read was issued last cycle; dout lands now
  logic                    flush_pend, flush_pend_nxt;
  logic                    rd_en, accept, clr;
  logic [BYTE_W*BYTES-1:0] lanes;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_en          = (state == FILL) && !bus.empty && (issued < FULL) && !flush_pend && !rst;
    accept         = (state == EMIT) && bus.out_ready;
    issued_nxt     = issued + CW'(rd_en);
    captured_nxt   = captured + CW'(pend);
    flush_pend_nxt = flush_pend;
    state_nxt      = state;
    clr            = 1'b0;

    unique case (state)
      FILL: begin
        if (flush_pend && !pend) begin
          flush_pend_nxt = 1'b0;
          if (captured != '0) state_nxt = EMIT;
        end else if (captured_nxt == FULL && !rd_en) begin
          state_nxt = EMIT;
        end else if (issued_nxt == FULL && rd_en) begin
          state_nxt = DRAIN;
        end
        if (flush) flush_pend_nxt = 1'b1;
      end
      DRAIN: begin
        if (pend) state_nxt = EMIT;
      end
      EMIT: begin
        if (accept) begin
          state_nxt    = FILL;
          issued_nxt   = '0;
          captured_nxt = '0;
          clr          = 1'b1;
        end
      end
      default: state_nxt = FILL;
    endcase

    // A word that completes makes any flush request moot.
    if (state_nxt != FILL) flush_pend_nxt = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state      <= FILL;
      issued     <= '0;
      captured   <= '0;
      pend       <= 1'b0;
      flush_pend <= 1'b0;
      words_out  <= '0;
    end else begin
      state      <= state_nxt;
      issued     <= issued_nxt;
      captured   <= captured_nxt;
      pend       <= rd_en;
      flush_pend <= flush_pend_nxt;
      if (accept) words_out <= words_out + CNT_W'(1);
    end
  end

  lane_packer #(
    .BYTES (BYTES),
    .IW    (IW)
  ) u_lanes (
    .clk  (rd_clk),
    .rst  (rst),
    .clr  (clr),
    .we   (pend),
    .idx  (captured[IW-1:0]),
    .din  (bus.dout),
    .data (lanes)
  );

  assign bus.rd_en     = rd_en;
  assign bus.out_valid = (state == EMIT);
  assign bus.out_bytes = (state == EMIT) ? captured : '0;
  assign bus.out_data  = (state == EMIT) ? lanes : '0;
  assign busy          = (state != FILL) || (captured != '0);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: behavioural FIFO, expected-word queue,
// directed scenarios followed by a randomized stream of full and flushed words.
module tb_fifo_rd_packer;
  import fifo_rd_pkg::*;

  localparam int BYTES = 4;
  localparam int CNT_W = 4;

  typedef struct {
    logic [31:0] data;
    int          nb;
  } word_t;

  logic             rd_clk = 1'b0;
  logic             rst    = 1'b1;
  logic             flush  = 1'b0;
  logic [CNT_W-1:0] words_out;
  logic             busy;

  fifo_rd_packer_if #(.BYTES(BYTES)) bus ();

  fifo_rd_packer #(.BYTES(BYTES), .CNT_W(CNT_W)) dut (
    .rd_clk    (rd_clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .words_out (words_out),
    .busy      (busy)
  );

  always #5 rd_clk = ~rd_clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          acc_cnt = 0;
  int          rd_cnt, first_rd, first_val;
  bit          chk_words = 1'b0;
  bit          stall = 1'b0;
  logic [7:0]  fifo_q[$];
  word_t       exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr_stats();
    rd_cnt    = 0;
    first_rd  = -1;
    first_val = -1;
  endtask

  // Observes the cycle just before the coming edge: handshakes and FIFO pops.
  task automatic mon();
    word_t w;
    if (rst) begin
      acc_cnt   = 0;
      chk_words = 1'b0;
    end else begin
      if (chk_words) begin
        check("words_out", 64'(words_out), 64'(acc_cnt % (1 << CNT_W)));
        chk_words = 1'b0;
      end
      if (bus.rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        check("no_underflow", 64'(bus.empty), 64'(0));
      end
      if (bus.out_valid && first_val < 0) first_val = cyc;
      if (bus.out_valid && bus.out_ready) begin
        check("word_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("out_data", 64'(bus.out_data), 64'(w.data));
          check("out_bytes", 64'(bus.out_bytes), 64'(w.nb));
        end
        acc_cnt++;
        chk_words = 1'b1;
      end
    end
  endtask

  // One clock: monitor at negedge, then FIFO model and input updates just after posedge.
  task automatic tick();
    bit pop;
    @(negedge rd_clk);
    mon();
    pop = bus.rd_en && !rst;
    @(posedge rd_clk);
    #1;
    if (pop && fifo_q.size() > 0) bus.dout = fifo_q.pop_front();
    bus.empty = (fifo_q.size() == 0) || stall;
    cyc++;
  endtask

  task automatic rtick();
    stall         = ($urandom_range(0, 3) == 0);
    bus.out_ready = ($urandom_range(0, 2) != 0);
    tick();
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (acc_cnt < n && k < budget) begin
      rtick();
      k++;
    end
    check("accept_timeout", 64'(acc_cnt >= n), 64'(1));
  endtask

  task automatic push_word(input logic [31:0] d, input int nb);
    for (int i = 0; i < nb; i++) fifo_q.push_back(d[8*i +: 8]);
    exp_q.push_back('{data: d, nb: nb});
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, k, sent;
    logic [31:0] d;

    bus.empty     = 1'b1;
    bus.dout      = '0;
    bus.out_ready = 1'b0;
    clr_stats();

    // Reset state
    repeat (3) tick();
    check("rst_rd_en", 64'(bus.rd_en), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_out_bytes", 64'(bus.out_bytes), 64'(0));
    check("rst_words_out", 64'(words_out), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    tick();

    // Full word, ready held high: 4 reads, valid five cycles after the first read
    clr_stats();
    bus.out_ready = 1'b1;
    push_word(32'h0403_0201, 4);
    k = 0;
    while (acc_cnt < 1 && k < 30) begin tick(); k++; end
    tick();
    check("t1_accepted", 64'(acc_cnt), 64'(1));
    check("t1_rd_cycles", 64'(rd_cnt), 64'(4));
    check("t1_valid_latency", 64'(first_val - first_rd), 64'(5));
    check("t1_words_out", 64'(words_out), 64'(1));

    // Three bytes then flush: partial word, no fourth read
    clr_stats();
    push_word(32'h0003_0201, 3);
    repeat (8) tick();
    check("t2_no_valid_before_flush", 64'(bus.out_valid), 64'(0));
    check("t2_busy_partial", 64'(busy), 64'(1));
    pulse_flush();
    k = 0;
    while (acc_cnt < 2 && k < 20) begin tick(); k++; end
    check("t2_accepted", 64'(acc_cnt), 64'(2));
    check("t2_rd_cycles", 64'(rd_cnt), 64'(3));

    // Backpressure: word held 10 cycles, more bytes waiting but not read
    bus.out_ready = 1'b0;
    base = acc_cnt;
    push_word(32'hDDCC_BBAA, 4);
    k = 0;
    while (!bus.out_valid && k < 20) begin tick(); k++; end
    check("t3_valid_seen", 64'(bus.out_valid), 64'(1));
    push_word(32'h1413_1211, 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_valid", 64'(bus.out_valid), 64'(1));
      check("t3_hold_rd_en", 64'(bus.rd_en), 64'(0));
      check("t3_hold_data", 64'(bus.out_data), 64'(exp_q[0].data));
    end
    bus.out_ready = 1'b1;
    tick();
    check("t3_accept_on_ready", 64'(acc_cnt), 64'(base + 1));
    k = 0;
    while (acc_cnt < base + 2 && k < 30) begin tick(); k++; end
    check("t3_second_word", 64'(acc_cnt), 64'(base + 2));

    // Flush with the FIFO empty: nothing happens
    repeat (3) tick();
    clr_stats();
    stall = 1'b1;
    pulse_flush();
    repeat (6) tick();
    check("t4_no_rd_en", 64'(rd_cnt), 64'(0));
    check("t4_no_valid", 64'(first_val < 0), 64'(1));
    check("t4_busy", 64'(busy), 64'(0));
    stall = 1'b0;

    // Reset after two captures: stale bytes must not leak into the next word
    fifo_q.push_back(8'hC1);
    fifo_q.push_back(8'hC2);
    repeat (4) tick();
    check("t5_busy_before_rst", 64'(busy), 64'(1));
    rst = 1'b1;
    repeat (2) tick();
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_words_out", 64'(words_out), 64'(0));
    rst = 1'b0;
    exp_q.delete();
    push_word(32'hA4A3_A2A1, 4);
    k = 0;
    while (acc_cnt < 1 && k < 30) begin tick(); k++; end
    check("t5_accepted", 64'(acc_cnt), 64'(1));

    // Random stream of 17 words (full or flushed partial); words_out wraps to 1
    rst = 1'b1;
    repeat (2) tick();
    rst  = 1'b0;
    exp_q.delete();
    sent = 0;
    for (int w = 0; w < 17; w++) begin
      k = ($urandom_range(0, 2) == 0) ? $urandom_range(1, BYTES - 1) : BYTES;
      d = '0;
      for (int i = 0; i < k; i++) d[8*i +: 8] = 8'($urandom);
      if (k < BYTES) begin
        wait_acc(sent, 400);
        push_word(d, k);
        stall = 1'b0;
        repeat (k + 5) tick();
        pulse_flush();
      end else begin
        push_word(d, k);
        repeat ($urandom_range(0, 3)) rtick();
      end
      sent++;
    end
    wait_acc(17, 2000);
    stall = 1'b0;
    repeat (2) tick();
    check("t6_words_out_wrap", 64'(words_out), 64'(1));
    check("t6_all_words_seen", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
